// File: rtl/snes_pad_reader_pkg.sv
// Shared types and constants for the SNES pad reader: poll FSM states,
// register window offsets and the default window base address.
package snes_pad_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LO,
        CLK_HI,
        COMMIT
    } state_t;

    localparam logic [12:0] OFS_BUTTONS       = 13'd0;
    localparam logic [12:0] OFS_EDGES         = 13'd1;
    localparam logic [12:0] OFS_COUNT         = 13'd2;
    localparam logic [12:0] DEFAULT_BASE_ADDR = 13'h1F00;

endpackage

// File: rtl/snes_pad_reader_sync.sv
// Two-flop synchroniser for the asynchronous pad data line; resets to the
// released level so nothing looks pressed straight out of reset.
module pad_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/snes_pad_reader.sv
// SNES pad poller with a three-word read-only register window:
// current buttons, sticky press-edges (clear on read) and a poll counter.
module snes_pad_reader
    import snes_pad_reader_pkg::*;
#(
    parameter int          CLK_DIV     = 300,
    parameter int          POLL_PERIOD = 833333,
    parameter int          NUM_BITS    = 16,
    parameter logic [12:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic                clock,
    input  logic                reset,
    output logic                pad_latch,
    output logic                pad_clk,
    input  logic                pad_data,
    input  logic [12:0]         address,
    input  logic                rd_en,
    output logic                hit,
    output logic [31:0]         rd_data,
    output logic [NUM_BITS-1:0] buttons,
    output logic                new_frame
);

    localparam int DIV_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam int BIT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int TMR_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NUM_BITS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_PERIOD - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [DIV_W-1:0]    r_div;
    logic [BIT_W-1:0]    r_bit;
    logic [TMR_W-1:0]    r_tmr;
    logic [NUM_BITS-1:0] r_shift;
    logic [NUM_BITS-1:0] r_buttons;
    logic [NUM_BITS-1:0] r_edges;
    logic [31:0]         r_poll_count;
    logic [31:0]         r_rd_data;
    logic                r_new_frame;

    logic                w_pad_sync;
    logic                w_latch;
    logic                w_pclk;
    logic                w_tmr_wrap;
    logic                w_sample;
    logic                w_clr;
    logic                w_hit;
    logic [12:0]         w_ofs;
    logic [31:0]         w_rd_mux;

    pad_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .i_d   (pad_data),
        .o_q   (w_pad_sync)
    );

    assign w_tmr_wrap = (r_tmr == TMR_LAST);
    assign w_sample   = (r_state == CLK_LO) && (r_div == HALF_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_pclk       = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_tmr_wrap) w_state_next = LATCH;
            end
            LATCH: begin
                w_latch = 1'b1;
                if (r_div == LATCH_LAST) w_state_next = CLK_LO;
            end
            CLK_LO: begin
                w_pclk = 1'b0;
                if (r_div == HALF_LAST) w_state_next = CLK_HI;
            end
            CLK_HI: begin
                if (r_div == HALF_LAST) begin
                    w_state_next = (r_bit == BIT_LAST) ? COMMIT : CLK_LO;
                end
            end
            COMMIT: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Phase counter restarts on every state change so each phase is timed alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_state_next != r_state) begin
            r_div <= '0;
        end else if (r_state inside {LATCH, CLK_LO, CLK_HI}) begin
            r_div <= r_div + 1'b1;
        end else begin
            r_div <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit   <= '0;
            r_tmr   <= '0;
            r_shift <= '0;
        end else begin
            r_tmr <= w_tmr_wrap ? '0 : r_tmr + 1'b1;
            if (r_state == LATCH) begin
                r_bit <= '0;
            end else if (r_state == CLK_HI && r_div == HALF_LAST) begin
                r_bit <= r_bit + 1'b1;
            end
            if (w_sample) r_shift[r_bit] <= ~w_pad_sync;
        end
    end

    assign w_clr = rd_en && (address == BASE_ADDR + OFS_EDGES);

    // A commit and a read-clear in the same cycle keep only this poll's new edges.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_buttons    <= '0;
            r_edges      <= '0;
            r_poll_count <= '0;
            r_new_frame  <= 1'b0;
        end else begin
            r_new_frame <= (r_state == COMMIT);
            if (r_state == COMMIT) begin
                r_buttons    <= r_shift;
                r_edges      <= (r_edges & ~{NUM_BITS{w_clr}}) | (r_shift & ~r_buttons);
                r_poll_count <= r_poll_count + 32'd1;
            end else if (w_clr) begin
                r_edges <= '0;
            end
        end
    end

    assign w_ofs = address - BASE_ADDR;
    assign w_hit = (address >= BASE_ADDR) && (w_ofs <= OFS_COUNT);

    always_comb begin
        w_rd_mux = 32'd0;
        if (w_hit) begin
            case (w_ofs)
                OFS_BUTTONS: w_rd_mux = 32'(r_buttons);
                OFS_EDGES:   w_rd_mux = 32'(r_edges);
                OFS_COUNT:   w_rd_mux = r_poll_count;
                default:     w_rd_mux = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_data <= 32'd0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign pad_latch = w_latch;
    assign pad_clk   = w_pclk;
    assign hit       = w_hit;
    assign rd_data   = r_rd_data;
    assign buttons   = r_buttons;
    assign new_frame = r_new_frame;

endmodule
